// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter that owns a single shared WIDTH-bit register.
// Each write returns a one-cycle grant and is followed by an optional hold window.
module reg_share_arbiter #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int HOLD  = 2
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [N-1:0]         Req,
    input  logic [N*WIDTH-1:0]   Data,
    output logic [N-1:0]         Gnt,
    output logic [WIDTH-1:0]     Q,
    output logic [$clog2(N)-1:0] Owner,
    output logic                 Valid,
    output logic                 Busy
);
    localparam int PW = $clog2(N);

    typedef enum logic {S_IDLE, S_HOLD} state_t;

    state_t        state;
    logic [PW-1:0] ptr;
    logic [3:0]    cnt;
    logic [N-1:0]  ereq;
    logic [PW-1:0] sel;
    logic [PW-1:0] ptr_next;
    logic [N-1:0]  sel_onehot;
    logic          found;

    // A requester whose grant is currently visible is masked so it cannot win twice in a row.
    always_comb begin
        ereq  = Req & ~Gnt;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && ereq[(int'(ptr) + k) % N]) begin
                found = 1'b1;
                sel   = PW'((int'(ptr) + k) % N);
            end
        end
    end

    assign ptr_next   = (sel == PW'(N - 1)) ? '0 : sel + 1'b1;
    assign sel_onehot = {{(N-1){1'b0}}, 1'b1} << sel;
    assign Busy       = (state == S_HOLD);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state <= S_IDLE;
            ptr   <= '0;
            cnt   <= '0;
            Gnt   <= '0;
            Q     <= '0;
            Owner <= '0;
            Valid <= 1'b0;
        end else begin
            Gnt <= '0;
            case (state)
                S_IDLE: begin
                    if (found) begin
                        Q     <= Data[int'(sel)*WIDTH +: WIDTH];
                        Gnt   <= sel_onehot;
                        Owner <= sel;
                        Valid <= 1'b1;
                        ptr   <= ptr_next;
                        if (HOLD > 0) begin
                            state <= S_HOLD;
                            cnt   <= 4'(HOLD);
                        end
                    end
                end
                S_HOLD: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_reg_share_arbiter.sv
// Directed bench for reg_share_arbiter: one instance with HOLD=2, one with HOLD=0.
module tb_reg_share_arbiter;
    logic        Clk;
    logic        Rst;
    logic [3:0]  req2, req0;
    logic [31:0] data2, data0;
    logic [3:0]  gnt2, gnt0;
    logic [7:0]  q2, q0;
    logic [1:0]  own2, own0;
    logic        vld2, vld0, busy2, busy0;

    int n_vec = 0;
    int n_err = 0;

    reg_share_arbiter #(.N(4), .WIDTH(8), .HOLD(2)) dut2 (
        .Clk(Clk), .Rst(Rst), .Req(req2), .Data(data2),
        .Gnt(gnt2), .Q(q2), .Owner(own2), .Valid(vld2), .Busy(busy2)
    );

    reg_share_arbiter #(.N(4), .WIDTH(8), .HOLD(0)) dut0 (
        .Clk(Clk), .Rst(Rst), .Req(req0), .Data(data0),
        .Gnt(gnt0), .Q(q0), .Owner(own0), .Valid(vld0), .Busy(busy0)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    int         exp_own [5] = '{0, 1, 2, 3, 0};
    logic [3:0] exp_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [7:0] exp_q   [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};

    initial begin
        Rst   = 1'b1;
        req2  = '0;
        req0  = '0;
        data2 = '0;
        data0 = '0;

        // asynchronous reset at power-up
        #2 Rst = 1'b0;
        #1;
        check("rst_q",     32'(q2),    32'h0);
        check("rst_gnt",   32'(gnt2),  32'h0);
        check("rst_owner", 32'(own2),  32'h0);
        check("rst_valid", 32'(vld2),  32'h0);
        check("rst_busy",  32'(busy2), 32'h0);
        repeat (2) tick();
        Rst = 1'b1;

        // single write from requester 0
        req2  = 4'b0001;
        data2 = 32'h0000_00A5;
        tick();
        check("sw_gnt",   32'(gnt2),  32'h1);
        check("sw_q",     32'(q2),    32'hA5);
        check("sw_owner", 32'(own2),  32'h0);
        check("sw_valid", 32'(vld2),  32'h1);
        check("sw_busy1", 32'(busy2), 32'h1);
        req2  = '0;
        data2 = 32'h0000_0011;
        tick();
        check("sw_gnt_drop", 32'(gnt2),  32'h0);
        check("sw_busy2",    32'(busy2), 32'h1);
        check("sw_q_stable", 32'(q2),    32'hA5);
        tick();
        check("sw_busy_end", 32'(busy2), 32'h0);

        // reset during the grant cycle with Q = 0x5A
        req2  = 4'b0010;
        data2 = 32'h0000_5A00;
        tick();
        check("pre_q",     32'(q2),    32'h5A);
        check("pre_busy",  32'(busy2), 32'h1);
        check("pre_owner", 32'(own2),  32'h1);
        req2 = '0;
        #2 Rst = 1'b0;
        #1;
        check("mid_rst_q",     32'(q2),    32'h0);
        check("mid_rst_gnt",   32'(gnt2),  32'h0);
        check("mid_rst_valid", 32'(vld2),  32'h0);
        check("mid_rst_busy",  32'(busy2), 32'h0);
        check("mid_rst_owner", 32'(own2),  32'h0);
        #2 Rst = 1'b1;

        // rotation with all four requesting
        data2 = 32'h4433_2211;
        req2  = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            tick();
            check("rot_gnt",   32'(gnt2), 32'(exp_gnt[g]));
            check("rot_owner", 32'(own2), 32'(exp_own[g]));
            check("rot_q",     32'(q2),   32'(exp_q[g]));
            if (g < 4) begin
                tick();
                check("rot_gap", 32'(gnt2), 32'h0);
                tick();
            end
        end

        // request raised during hold is served right after Busy falls
        req2 = 4'b0010;
        tick();
        check("rdh_busy1", 32'(busy2), 32'h1);
        check("rdh_gnt1",  32'(gnt2),  32'h0);
        tick();
        check("rdh_busy0", 32'(busy2), 32'h0);
        check("rdh_gnt2",  32'(gnt2),  32'h0);
        tick();
        check("rdh_gnt",   32'(gnt2), 32'h2);
        check("rdh_owner", 32'(own2), 32'h1);
        check("rdh_q",     32'(q2),   32'h22);
        req2 = '0;
        repeat (2) tick();

        // reset inside a hold window returns the pointer to 0
        req2 = 4'b0100;
        tick();
        check("hr_owner", 32'(own2),  32'h2);
        check("hr_busy",  32'(busy2), 32'h1);
        req2 = '0;
        tick();
        #2 Rst = 1'b0;
        #1;
        check("hr_rst_busy", 32'(busy2), 32'h0);
        #2 Rst = 1'b1;
        req2 = 4'b1001;
        tick();
        check("hr_gnt",   32'(gnt2), 32'h1);
        check("hr_owner2", 32'(own2), 32'h0);
        check("hr_q",     32'(q2),   32'h11);
        req2 = '0;
        repeat (2) tick();

        // HOLD=0: two requesters alternate every cycle, pointer wraps
        data0 = 32'h1300_0010;
        req0  = 4'b1001;
        tick();
        check("wr_gnt0",  32'(gnt0),  32'h1);
        check("wr_q0",    32'(q0),    32'h10);
        check("wr_busy0", 32'(busy0), 32'h0);
        tick();
        check("wr_gnt1",  32'(gnt0), 32'h8);
        check("wr_own1",  32'(own0), 32'h3);
        check("wr_q1",    32'(q0),   32'h13);
        tick();
        check("wr_gnt2",  32'(gnt0), 32'h1);
        check("wr_own2",  32'(own0), 32'h0);
        tick();
        check("wr_gnt3",  32'(gnt0), 32'h8);

        // HOLD=0: single requester is granted every other cycle
        req0  = 4'b0100;
        data0 = 32'h0077_0000;
        tick();
        check("mk_gnt0", 32'(gnt0), 32'h4);
        check("mk_q0",   32'(q0),   32'h77);
        data0 = 32'h0088_0000;
        tick();
        check("mk_gnt1", 32'(gnt0), 32'h0);
        check("mk_q1",   32'(q0),   32'h77);
        tick();
        check("mk_gnt2", 32'(gnt0), 32'h4);
        check("mk_q2",   32'(q0),   32'h88);
        req0 = '0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/reg_share_arbiter.md
# reg_share_arbiter

Round-robin arbiter that shares one WIDTH-bit storage register (a bank of D flip-flops with asynchronous active-low clear) among N requesters. Each requester presents a write request with data; the arbiter selects one winner per grant, loads the winner's data into the shared register, and returns a one-cycle registered grant. A programmable hold window after each write keeps the stored value stable for downstream consumers before the next write. The block sits between the requesting datapath stages and the shared register and is the only writer of that register.

## Interface
- N, 4: number of requesters (2..8)
- WIDTH, 8: width of the shared register and of each data port
- HOLD, 2: idle cycles enforced after every write (0 disables; max 15)
- Clk  input  1  system clock, all state updates on rising edge
- Rst  input  1  reset, asynchronous, active-low; clears all state immediately
- Req  input  N  request vector; Req[i] held high by requester i until it sees Gnt[i]
- Data  input  N*WIDTH  packed write data, requester i at [i*WIDTH +: WIDTH]
- Gnt  output  N  registered one-hot grant, high for exactly one cycle per write
- Q  output  WIDTH  shared register contents
- Owner  output  clog2(N)  index of the requester that last wrote Q
- Valid  output  1  high once Q has been written since reset
- Busy  output  1  high during the hold window

## Operation
- State: FSM {IDLE, HOLD}, round-robin pointer ptr (clog2(N) bits), hold counter cnt (4 bits).
- Effective request: EReq = Req & ~Gnt (a requester is masked in the cycle its grant is visible).
- IDLE, EReq == 0: nothing changes; Gnt = 0.
- IDLE, EReq != 0: sel = first i with EReq[i] set, searching ptr, ptr+1, ... wrapping mod N. On the edge: Q <= Data[sel]; Gnt <= one-hot(sel); Owner <= sel; Valid <= 1; ptr <= (sel+1) mod N (wraps N-1 -> 0). If HOLD > 0: state <= HOLD, cnt <= HOLD; else remain IDLE.
- HOLD: Busy = 1; no grants; Gnt cleared after its one cycle; cnt decrements each edge; when cnt == 1, state <= IDLE on that edge.
- Requests arriving during HOLD are not lost; they are arbitrated in the first IDLE cycle.
- Data[i] is sampled only on the granting edge; changes at other times have no effect on Q.
- Busy is combinational from state (state == HOLD); all other outputs are registered.

## Timing
- Reset values (async, no clock needed): Q = 0, Gnt = 0, Owner = 0, Valid = 0, Busy = 0, ptr = 0, cnt = 0, state IDLE.
- Reset asserted mid-HOLD or during a Gnt cycle: all of the above cleared immediately; the in-flight grant is withdrawn; the requester must retry.
- Latency: Req sampled high in IDLE at edge k -> Gnt and new Q visible in the cycle after edge k.
- Throughput: one write per HOLD+1 cycles; with HOLD = 0, one write per cycle if at least two requesters are active.
- A single continuously asserted requester with HOLD = 0 is granted every other cycle (masking rule).
- Busy rises in the same cycle as Gnt and stays high for exactly HOLD cycles.
- Rst release: first grant occurs at earliest on the first rising edge after Rst goes high.

## Test plan
- Reset: drive Rst low mid-run with Q = 0x5A, Busy = 1 -> Q = 0, Gnt = 0, Valid = 0, Busy = 0, Owner = 0 immediately, with no clock edge.
- Single write (N=4, WIDTH=8, HOLD=2): Req = 0001, Data[0] = 0xA5 -> next cycle Gnt = 0001, Q = 0xA5, Owner = 0, Valid = 1; Busy high 2 cycles; Gnt low after 1 cycle.
- Rotation: Req = 1111 held, HOLD = 2 -> Owner sequence 0,1,2,3,0 with grants 3 cycles apart; Q tracks Data of each owner.
- Wrap/fairness, HOLD = 0: Req = 1001 held from ptr = 0 -> Gnt alternates 0001, 1000 every cycle; pointer wraps 3 -> 0.
- Masking, HOLD = 0: only Req[2] held -> Gnt = 0100 every other cycle, Q updated only on those edges.
- Request during hold: grant to requester 0, Req[1] raised during HOLD -> Gnt = 0010 exactly in the cycle after Busy falls; reset asserted in a later HOLD window -> after release, next grant searches from ptr = 0.
